// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ clients.
// Latches the winner's request, launches the master and reports done/err.
module i2c_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TW          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [5*NREQ-1:0] req_nbyte,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              m_ena,
    output logic              m_rw,
    output logic [6:0]        m_addr,
    output logic [4:0]        m_n_byte,
    output logic              m_abort,
    input  logic [3:0]        m_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);
    localparam logic [3:0] MS_IDLE = 4'd0;
    localparam logic [3:0] MS_STOP = 4'd8;

    typedef enum logic [2:0] {
        S_ARB,
        S_LAUNCH,
        S_BUSY,
        S_STOPW,
        S_FIN,
        S_ABORT
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic [6:0]      addr_q, addr_d;
    logic [4:0]      nb_q, nb_d;

    logic            any_req;
    logic [IW-1:0]   pick;
    logic            rw_sel;
    logic [6:0]      addr_sel;
    logic [4:0]      nb_sel;
    logic [TW-1:0]   cnt_inc;
    logic            tmo;
    logic [IW-1:0]   ptr_inc;
    logic [NREQ-1:0] onehot;

    // Search starts at the rr pointer and wraps past the last client.
    always_comb begin
        int j;
        logic [IW-1:0] idx;
        j       = 0;
        idx     = '0;
        any_req = 1'b0;
        pick    = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = IW'(j);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        rw_sel   = 1'b0;
        addr_sel = '0;
        nb_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                rw_sel   = req_rw[i];
                addr_sel = req_addr[7*i +: 7];
                nb_sel   = req_nbyte[5*i +: 5];
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);
    assign tmo     = (cnt_inc == TMO);
    assign ptr_inc = (win_q == LAST) ? '0 : win_q + IW'(1);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        nb_d    = nb_q;
        unique case (state_q)
            S_ARB: begin
                if (any_req) begin
                    win_d   = pick;
                    rw_d    = rw_sel;
                    addr_d  = addr_sel;
                    nb_d    = nb_sel;
                    cnt_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d = cnt_inc;
                if (tmo) state_d = S_ABORT;
                else if (m_state != MS_IDLE) state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_inc;
                if (tmo) state_d = S_ABORT;
                else if (m_state == MS_STOP) state_d = S_STOPW;
            end
            S_STOPW: begin
                cnt_d = cnt_inc;
                if (tmo) state_d = S_ABORT;
                else if (m_state == MS_IDLE) state_d = S_FIN;
            end
            S_FIN, S_ABORT: begin
                ptr_d   = ptr_inc;
                state_d = S_ARB;
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ARB;
            win_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            nb_q    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            nb_q    <= nb_d;
        end
    end

    // Grant stays with the winner until the FSM is back in ARB.
    assign onehot   = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
    assign gnt      = (state_q != S_ARB) ? onehot : '0;
    assign done     = (state_q == S_FIN) ? onehot : '0;
    assign err      = (state_q == S_ABORT) ? onehot : '0;
    assign m_ena    = (state_q == S_LAUNCH);
    assign m_abort  = (state_q == S_ABORT);
    assign m_rw     = rw_q;
    assign m_addr   = addr_q;
    assign m_n_byte = nb_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: arbitration table, corner sequences
// and random transactions against a transaction-level model.
module tb_i2c_req_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_rw;
    logic [27:0] req_addr;
    logic [19:0] req_nbyte;
    logic [3:0]  gnt, done, err;
    logic        m_ena, m_rw, m_abort;
    logic [6:0]  m_addr;
    logic [4:0]  m_n_byte;
    logic [3:0]  m_state;

    int nvec = 0;
    int nfail = 0;
    int mptr = 0;

    i2c_req_arbiter #(
        .NREQ(NREQ), .TIMEOUT_CYC(TMO), .TW(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_nbyte(req_nbyte),
        .gnt(gnt), .done(done), .err(err),
        .m_ena(m_ena), .m_rw(m_rw),
        .m_addr(m_addr), .m_n_byte(m_n_byte),
        .m_abort(m_abort), .m_state(m_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rq;
        logic [6:0] base;
        logic [3:0] rw;
        logic [3:0] eg;
        logic [6:0] ea;
        logic       erw;
        logic [4:0] enb;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("done_err_excl", 32'(done & err), 32'(0));
    endtask

    function automatic int win_of(input logic [3:0] g);
        for (int i = 0; i < NREQ; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Caller has driven req at posedge+1 with the DUT idle in arbitration.
    task automatic run_txn(input logic [3:0] eg, input logic [6:0] ea,
                           input logic erw, input logic [4:0] enb,
                           input bit stuck, input bit scr);
        int k;
        int d;
        step();
        k = 0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("m_ena_launch", 32'(m_ena), 32'(1));
        chk("m_addr", 32'(m_addr), 32'(ea));
        chk("m_rw", 32'(m_rw), 32'(erw));
        chk("m_n_byte", 32'(m_n_byte), 32'(enb));
        if (scr) begin
            req_addr  = {4{7'h55}};
            req_rw    = ~req_rw;
            req_nbyte = ~req_nbyte;
            req       = req & ~eg;
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
            step();
            k++;
            chk("m_ena_hold", 32'(m_ena), 32'(1));
            chk("gnt_hold", 32'(gnt), 32'(eg));
        end
        m_state = 4'd1;
        step();
        k++;
        chk("m_ena_drop", 32'(m_ena), 32'(0));
        chk("gnt_busy", 32'(gnt), 32'(eg));
        chk("m_addr_busy", 32'(m_addr), 32'(ea));
        if (stuck) begin
            m_state = 4'd4;
            while (k < TMO - 1) begin
                step();
                k++;
                chk("no_early_err", 32'(err | done), 32'(0));
                chk("no_early_abort", 32'(m_abort), 32'(0));
            end
            step();
            chk("m_abort", 32'(m_abort), 32'(1));
            chk("err_pulse", 32'(err), 32'(eg));
            chk("no_done_tmo", 32'(done), 32'(0));
            chk("m_ena_tmo", 32'(m_ena), 32'(0));
            m_state = 4'd0;
            step();
            chk("abort_single", 32'(m_abort), 32'(0));
            chk("err_single", 32'(err), 32'(0));
            chk("gnt_clr_tmo", 32'(gnt), 32'(0));
        end else begin
            for (int s = 2; s <= 8; s++) begin
                m_state = 4'(s);
                repeat ($urandom_range(1, 3)) begin
                    step();
                    chk("no_early_done", 32'(done | err), 32'(0));
                    chk("gnt_walk", 32'(gnt), 32'(eg));
                    chk("m_ena_walk", 32'(m_ena), 32'(0));
                end
            end
            m_state = 4'd0;
            step();
            chk("done_pulse", 32'(done), 32'(eg));
            chk("no_err", 32'(err), 32'(0));
            chk("m_addr_fin", 32'(m_addr), 32'(ea));
            step();
            chk("done_single", 32'(done), 32'(0));
            chk("gnt_clr", 32'(gnt), 32'(0));
        end
        mptr = (win_of(eg) + 1) % NREQ;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        tbl[0] = '{4'b0001, 7'h10, 4'b0000, 4'b0001, 7'h10, 1'b0, 5'd0};
        tbl[1] = '{4'b1111, 7'h20, 4'b0010, 4'b0010, 7'h21, 1'b1, 5'd1};
        tbl[2] = '{4'b1111, 7'h30, 4'b0010, 4'b0100, 7'h32, 1'b0, 5'd2};
        tbl[3] = '{4'b1111, 7'h40, 4'b1000, 4'b1000, 7'h43, 1'b1, 5'd3};
        tbl[4] = '{4'b1111, 7'h50, 4'b0001, 4'b0001, 7'h50, 1'b1, 5'd0};
        tbl[5] = '{4'b0010, 7'h60, 4'b0000, 4'b0010, 7'h61, 1'b0, 5'd1};
        tbl[6] = '{4'b0011, 7'h70, 4'b0001, 4'b0001, 7'h70, 1'b1, 5'd0};
        tbl[7] = '{4'b1001, 7'h08, 4'b1111, 4'b1000, 7'h0B, 1'b1, 5'd3};
        tbl[8] = '{4'b0110, 7'h3C, 4'b0100, 4'b0010, 7'h3D, 1'b0, 5'd1};
        tbl[9] = '{4'b1000, 7'h00, 4'b1000, 4'b1000, 7'h03, 1'b1, 5'd3};

        rst = 1'b1;
        req = '0;
        req_rw = '0;
        req_addr = '0;
        req_nbyte = '0;
        m_state = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_m_ena", 32'(m_ena), 32'(0));
        chk("rst_m_abort", 32'(m_abort), 32'(0));
        chk("rst_m_addr", 32'(m_addr), 32'(0));
        rst = 1'b0;
        mptr = 0;

        step();
        chk("idle_no_gnt", 32'(gnt), 32'(0));

        for (int i = 0; i < 10; i++) begin
            req = tbl[i].rq;
            req_rw = tbl[i].rw;
            for (int c = 0; c < NREQ; c++) begin
                req_addr[7*c +: 7]  = tbl[i].base + 7'(c);
                req_nbyte[5*c +: 5] = 5'(c);
            end
            run_txn(tbl[i].eg, tbl[i].ea, tbl[i].erw, tbl[i].enb, 1'b0, 1'b0);
        end

        // Master stuck mid-transfer, pointer at 0.
        req = 4'b0100;
        req_addr[14 +: 7] = 7'h2A;
        req_rw = 4'b0100;
        req_nbyte[10 +: 5] = 5'd7;
        run_txn(4'b0100, 7'h2A, 1'b1, 5'd7, 1'b1, 1'b0);

        // Fields change after grant; wrap from pointer 3 to client 0.
        req = 4'b0001;
        req_addr[0 +: 7] = 7'h3C;
        req_rw = 4'b0000;
        req_nbyte[0 +: 5] = 5'd2;
        run_txn(4'b0001, 7'h3C, 1'b0, 5'd2, 1'b0, 1'b1);

        // Reset in BUSY, then pending client 2 from pointer 0.
        req = 4'b0010;
        req_addr[7 +: 7] = 7'h11;
        step();
        chk("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
        m_state = 4'd1;
        step();
        chk("pre_rst_busy", 32'(m_ena), 32'(0));
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'(0));
        chk("arst_m_ena", 32'(m_ena), 32'(0));
        chk("arst_done_err", 32'(done | err), 32'(0));
        chk("arst_abort", 32'(m_abort), 32'(0));
        chk("arst_m_addr", 32'(m_addr), 32'(0));
        m_state = 4'd0;
        req = 4'b0100;
        req_addr[14 +: 7] = 7'h66;
        req_rw = 4'b0000;
        req_nbyte[10 +: 5] = 5'd0;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        run_txn(4'b0100, 7'h66, 1'b0, 5'd0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            req = 4'($urandom_range(1, 15));
            req_rw = 4'($urandom);
            req_addr = 28'($urandom);
            req_nbyte = 20'($urandom);
            w = rr_pick(req, mptr);
            run_txn(4'b0001 << w, req_addr[7*w +: 7], req_rw[w],
                    req_nbyte[5*w +: 5], ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
